// File: rtl/cgra_clock_gate_ctrl.sv
// Per-column clock-enable sequencer: wakes gated CGRA columns on request and re-gates them after an idle period.
// Optional `CGRA_CG_STATS_EN adds per-column counters of cycles spent gated off.
module cgra_clock_gate_ctrl #(
    parameter int N_COL       = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_LAT    = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               test_en_i,
    input  logic               cg_enable_i,
    input  logic [N_COL-1:0]   col_req_i,
    input  logic [N_COL-1:0]   col_busy_i,
`ifdef CGRA_CG_STATS_EN
    input  logic               stats_clr_i,
    output logic [N_COL*32-1:0] gated_cyc_o,
`endif
    output logic [N_COL-1:0]   col_ack_o,
    output logic [N_COL-1:0]   clk_en_o,
    output logic [N_COL-1:0]   col_gated_o
);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_WAKE = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_IDLE = 2'd3;

    localparam logic [7:0] WAKE_INIT = 8'(WAKE_LAT - 1);
    localparam logic [7:0] IDLE_INIT = 8'(IDLE_CYCLES - 1);

    logic [1:0] state_q [N_COL];
    logic [1:0] state_d [N_COL];
    logic [7:0] cnt_q   [N_COL];
    logic [7:0] cnt_d   [N_COL];

    always_comb begin
        for (int i = 0; i < N_COL; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                S_OFF: begin
                    if (col_req_i[i] || !cg_enable_i) begin
                        state_d[i] = S_WAKE;
                        cnt_d[i]   = WAKE_INIT;
                    end
                end
                S_WAKE: begin
                    if (cnt_q[i] == 8'd0) state_d[i] = S_ON;
                    else                  cnt_d[i]   = cnt_q[i] - 8'd1;
                end
                S_ON: begin
                    if (!col_busy_i[i] && !col_req_i[i] && cg_enable_i) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = IDLE_INIT;
                    end
                end
                default: begin
                    // Any activity cancels the idle countdown, even on its final cycle
                    if (col_busy_i[i] || col_req_i[i] || !cg_enable_i) state_d[i] = S_ON;
                    else if (cnt_q[i] == 8'd0)                          state_d[i] = S_OFF;
                    else                                                cnt_d[i]   = cnt_q[i] - 8'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_COL; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= 8'd0;
            end
        end else begin
            for (int i = 0; i < N_COL; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Enables come straight from registered state so the gate cell never sees a glitch
    always_comb begin
        col_ack_o   = '0;
        clk_en_o    = '0;
        col_gated_o = '0;
        for (int i = 0; i < N_COL; i++) begin
            col_ack_o[i]   = (state_q[i] == S_ON) && col_req_i[i];
            clk_en_o[i]    = (state_q[i] != S_OFF) || test_en_i;
            col_gated_o[i] = (state_q[i] == S_OFF);
        end
    end

`ifdef CGRA_CG_STATS_EN
    logic [31:0] gcnt_q [N_COL];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_COL; i++) gcnt_q[i] <= 32'd0;
        end else begin
            for (int i = 0; i < N_COL; i++) begin
                if (stats_clr_i)
                    gcnt_q[i] <= 32'd0;
                else if ((state_q[i] == S_OFF) && (gcnt_q[i] != 32'hFFFF_FFFF))
                    gcnt_q[i] <= gcnt_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        gated_cyc_o = '0;
        for (int i = 0; i < N_COL; i++) gated_cyc_o[i*32 +: 32] = gcnt_q[i];
    end
`endif

endmodule

// File: tb/tb_cgra_clock_gate_ctrl.sv
// Bench for cgra_clock_gate_ctrl: timer-based column model checked every cycle plus directed literal checks.
module tb_cgra_clock_gate_ctrl;

    localparam int N     = 4;
    localparam int IDLE  = 16;
    localparam int WLAT  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           test_en = 1'b0;
    logic           cge = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   busy = '0;
    logic [N-1:0]   ack;
    logic [N-1:0]   clk_en;
    logic [N-1:0]   gated;
`ifdef CGRA_CG_STATS_EN
    logic           stats_clr = 1'b0;
    logic [N*32-1:0] gcyc;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    cgra_clock_gate_ctrl #(.N_COL(N), .IDLE_CYCLES(IDLE), .WAKE_LAT(WLAT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_en_i   (test_en),
        .cg_enable_i (cge),
        .col_req_i   (req),
        .col_busy_i  (busy),
`ifdef CGRA_CG_STATS_EN
        .stats_clr_i (stats_clr),
        .gated_cyc_o (gcyc),
`endif
        .col_ack_o   (ack),
        .clk_en_o    (clk_en),
        .col_gated_o (gated)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a column is either unpowered, counting down its wake time, or running;
    // while running it counts consecutive quiet cycles and powers down once they exceed IDLE.
    bit [N-1:0] m_pwr = '0;
    int         m_wake [N];
    int         m_quiet[N];

    initial for (int c = 0; c < N; c++) begin m_wake[c] = 0; m_quiet[c] = 0; end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pwr = '0;
            for (int c = 0; c < N; c++) begin m_wake[c] = 0; m_quiet[c] = 0; end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (!m_pwr[c]) begin
                    if (req[c] || !cge) begin
                        m_pwr[c] = 1'b1; m_wake[c] = WLAT; m_quiet[c] = 0;
                    end
                end else if (m_wake[c] > 0) begin
                    m_wake[c] = m_wake[c] - 1;
                end else if (!busy[c] && !req[c] && cge) begin
                    m_quiet[c] = m_quiet[c] + 1;
                    if (m_quiet[c] > IDLE) begin m_pwr[c] = 1'b0; m_quiet[c] = 0; end
                end else begin
                    m_quiet[c] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            logic [N-1:0] e_en, e_ack, e_gated;
            for (int c = 0; c < N; c++) begin
                e_en[c]    = m_pwr[c] | test_en;
                e_gated[c] = ~m_pwr[c];
                e_ack[c]   = m_pwr[c] && (m_wake[c] == 0) && (m_quiet[c] == 0) && req[c];
            end
            chk("model_clk_en", 32'(clk_en), 32'(e_en));
            chk("model_gated",  32'(gated),  32'(e_gated));
            chk("model_ack",    32'(ack),    32'(e_ack));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        mid();
        chk("rst_clk_en", 32'(clk_en), 32'h0);
        chk("rst_gated",  32'(gated),  32'hF);
        chk("rst_ack",    32'(ack),    32'h0);

`ifdef CGRA_CG_STATS_EN
        cyc(); stats_clr = 1'b1;
        cyc(); stats_clr = 1'b0;
        mid(); chk("stats_clr", gcyc[31:0], 32'd0);
        cyc(20);
        mid(); chk("stats_20", gcyc[31:0], 32'd20);
`endif

        // Wake column 0 from OFF
        cyc(); req = 4'b0001;
        mid(); chk("wake0_t0_en", 32'(clk_en), 32'h0);
        cyc(); mid(); chk("wake0_t1_en", 32'(clk_en), 32'h1);
        cyc(); mid(); chk("wake0_t2_ack", 32'(ack), 32'h0);
        cyc(); mid(); chk("wake0_t3_ack", 32'(ack), 32'h1);
        cyc(); busy = 4'b0001; req = 4'b0000;
        cyc(3); busy = 4'b0000;
        cyc(25);

        // Column 1: busy falls, idles out
        cyc(); req[1] = 1'b1;
        cyc(3); mid(); chk("col1_ack", 32'(ack[1]), 32'h1);
        cyc(); busy[1] = 1'b1; req[1] = 1'b0;
        cyc(2); busy[1] = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            cyc(); mid();
            if (k == 16) chk("idle1_t16_en", 32'(clk_en[1]), 32'h1);
            if (k == 17) chk("idle1_t17_en", 32'(clk_en[1]), 32'h0);
        end

        // Column 1 again: request arrives during IDLE
        cyc(); req[1] = 1'b1;
        cyc(3); busy[1] = 1'b1; req[1] = 1'b0;
        cyc(2); busy[1] = 1'b0;
        cyc(10); req[1] = 1'b1;
        mid(); chk("idle1_req_t10_ack", 32'(ack[1]), 32'h0);
        cyc(); mid(); chk("idle1_req_t11_ack", 32'(ack[1]), 32'h1);
        cyc(7); mid(); chk("idle1_req_t18_en", 32'(clk_en[1]), 32'h1);
        cyc(); req[1] = 1'b0;
        cyc(20);

        // Column 2: single-cycle request pulse
        cyc(); req[2] = 1'b1;
        cyc(); req[2] = 1'b0;
        cyc(2); mid();
        chk("pulse2_on_ack", 32'(ack[2]), 32'h0);
        chk("pulse2_on_en",  32'(clk_en[2]), 32'h1);
        cyc(16); mid(); chk("pulse2_t19_en", 32'(clk_en[2]), 32'h1);
        cyc();   mid(); chk("pulse2_t20_en", 32'(clk_en[2]), 32'h0);

        // test_en and cg_enable with every column OFF
        cyc(); test_en = 1'b1;
        #1;
        chk("test_en_clk_en", 32'(clk_en), 32'hF);
        chk("test_en_gated",  32'(gated),  32'hF);
        cyc(); test_en = 1'b0; cge = 1'b0;
        mid(); chk("cge0_t0_en", 32'(clk_en), 32'h0);
        cyc(); mid(); chk("cge0_t1_en", 32'(clk_en), 32'hF);
        cyc(5); mid();
        chk("cge0_hold_gated", 32'(gated), 32'h0);
        chk("cge0_hold_en",    32'(clk_en), 32'hF);
        cyc(); cge = 1'b1;
        cyc(22);

        // Asynchronous reset during WAKE of column 3, then while acking
        cyc(); req[3] = 1'b1;
        cyc(); #2 rst_n = 1'b0;
        #1;
        chk("arst_wake_en",    32'(clk_en), 32'h0);
        chk("arst_wake_gated", 32'(gated),  32'hF);
        chk("arst_wake_ack",   32'(ack),    32'h0);
        cyc(2); rst_n = 1'b1;
        cyc(3); mid(); chk("rewake3_ack", 32'(ack), 32'h8);
        cyc(); #2 rst_n = 1'b0;
        #1 chk("arst_on_ack", 32'(ack), 32'h0);
        cyc(); rst_n = 1'b1; req = '0;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
